// File: rtl/offchip_mem_pkg.sv
// Shared types and constants for the off-chip memory responder.
// The FSM state set and block-fill geometry live here.
package offchip_mem_pkg;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;
  localparam int LAT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    R_AACK,
    R_LAT,
    R_DATA,
    R_REL,
    W_AACK,
    W_DWAIT,
    W_DACK
  } state_t;

  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [LAT_W-1:0]  lat_t;

endpackage

// File: rtl/offchip_mem_slave_if.sv
// Shared off-chip bus between the cache (master) and the memory responder (slave).
interface offchip_mem_slave_if #(
  parameter int DW = 16
);

  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic          rrqst;
  logic          rrdy;
  logic          rdrdy;
  logic          rdacpt;
  logic          wrqst;
  logic          wacpt;

  modport master (
    output bus_in, rrqst, rdacpt, wrqst,
    input  bus_out, bus_oe, rrdy, rdrdy, wacpt
  );

  modport slave (
    input  bus_in, rrqst, rdacpt, wrqst,
    output bus_out, bus_oe, rrdy, rdrdy, wacpt
  );

endinterface

// File: rtl/mem_word_array.sv
// Single-port word RAM with synchronous write and registered (1-cycle) read.
module mem_word_array #(
  parameter int DW       = 16,
  parameter int DEPTH_L2 = 10
) (
  input  logic                clock,
  input  logic                we,
  input  logic                re,
  input  logic [DEPTH_L2-1:0] addr,
  input  logic [DW-1:0]       din,
  output logic [DW-1:0]       dout
);

  logic [DW-1:0] mem [2**DEPTH_L2];

  // NOTE: the array has no reset on purpose; contents must survive a reset pulse.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
    if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/offchip_mem_slave.sv
// Memory-side responder: 4-beat block reads and two-phase write-through over the
// shared off-chip bus, backed by a word-addressed RAM.
module offchip_mem_slave
  import offchip_mem_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int DEPTH_L2 = 10,
  parameter int RD_LAT   = 2
) (
  input logic               clock,
  input logic               reset,
  offchip_mem_slave_if.slave bus
);

  state_t        state;
  beat_t         beat;
  lat_t          lat;
  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr;
  logic          rd_pend;

  logic                ram_we;
  logic                ram_re;
  logic [DEPTH_L2-1:0] ram_addr;
  logic [DW-1:0]       ram_dout;
  logic [DEPTH_L2-1:0] rd_addr;

  // raddr is block aligned, so the beat index simply fills the low bits.
  assign rd_addr = {raddr[DEPTH_L2-1:BEAT_W], beat};

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = rd_addr;
    if (state == W_DWAIT && bus.wrqst) begin
      ram_we   = 1'b1;
      ram_addr = waddr[DEPTH_L2-1:0];
    end
    if (state == R_LAT && lat == '0) ram_re = 1'b1;
  end

  mem_word_array #(
    .DW       (DW),
    .DEPTH_L2 (DEPTH_L2)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .din   (bus.bus_in),
    .dout  (ram_dout)
  );

  // NOTE: state and outputs are sequential, so they use non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      beat        <= '0;
      lat         <= '0;
      raddr       <= '0;
      waddr       <= '0;
      rd_pend     <= 1'b0;
      bus.rrdy    <= 1'b0;
      bus.rdrdy   <= 1'b0;
      bus.wacpt   <= 1'b0;
      bus.bus_oe  <= 1'b0;
      bus.bus_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.wrqst) begin
            waddr     <= bus.bus_in[AW-1:0];
            rd_pend   <= bus.rrqst;
            bus.wacpt <= 1'b1;
            state     <= W_AACK;
          end else if (bus.rrqst) begin
            raddr    <= {bus.bus_in[AW-1:BEAT_W], {BEAT_W{1'b0}}};
            bus.rrdy <= 1'b1;
            state    <= R_AACK;
          end
        end
        R_AACK: begin
          if (!bus.rrqst) begin
            bus.rrdy <= 1'b0;
            lat      <= LAT_W'(RD_LAT);
            state    <= R_LAT;
          end
        end
        R_LAT: begin
          if (lat == '0) state <= R_DATA;
          else           lat   <= lat - 1'b1;
        end
        R_DATA: begin
          // First cycle here waits for the RAM word; afterwards hold until captured.
          if (!bus.rdrdy) begin
            bus.rdrdy   <= 1'b1;
            bus.bus_oe  <= 1'b1;
            bus.bus_out <= ram_dout;
          end else if (bus.rdacpt) begin
            bus.rdrdy  <= 1'b0;
            bus.bus_oe <= 1'b0;
            state      <= R_REL;
          end
        end
        R_REL: begin
          if (!bus.rdacpt) begin
            if (beat == beat_t'(BEATS - 1)) begin
              beat  <= '0;
              state <= IDLE;
            end else begin
              beat  <= beat + 1'b1;
              lat   <= LAT_W'(RD_LAT);
              state <= R_LAT;
            end
          end
        end
        W_AACK: begin
          if (!bus.wrqst) begin
            bus.wacpt <= 1'b0;
            state     <= W_DWAIT;
          end
        end
        W_DWAIT: begin
          if (bus.wrqst) begin
            bus.wacpt <= 1'b1;
            state     <= W_DACK;
          end
        end
        W_DACK: begin
          if (!bus.wrqst) begin
            bus.wacpt <= 1'b0;
            // Write-miss: the block fill follows without a second read request.
            if (rd_pend) begin
              raddr   <= {waddr[AW-1:BEAT_W], {BEAT_W{1'b0}}};
              rd_pend <= 1'b0;
              lat     <= LAT_W'(RD_LAT);
              state   <= R_LAT;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr[AW-1:DEPTH_L2], raddr[BEAT_W-1:0], waddr[AW-1:DEPTH_L2]};

endmodule

// File: tb/tb_offchip_mem_slave.sv
// Bench for offchip_mem_slave: directed protocol scenarios plus randomized block traffic
// checked against an array model of the RAM.
module tb_offchip_mem_slave;
  import offchip_mem_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  offchip_mem_slave_if #(.DW(16)) m  ();
  offchip_mem_slave_if #(.DW(16)) a0 ();
  offchip_mem_slave_if #(.DW(16)) a5 ();

  offchip_mem_slave #(.AW(16), .DW(16), .DEPTH_L2(10), .RD_LAT(2)) u_dut (
    .clock (clock), .reset (reset), .bus (m));
  offchip_mem_slave #(.AW(16), .DW(16), .DEPTH_L2(10), .RD_LAT(0)) u_l0 (
    .clock (clock), .reset (reset), .bus (a0));
  offchip_mem_slave #(.AW(16), .DW(16), .DEPTH_L2(10), .RD_LAT(5)) u_l5 (
    .clock (clock), .reset (reset), .bus (a5));

  int checks   = 0;
  int failures = 0;
  logic [15:0] model [0:1023];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic out_sel(input int sel);
    case (sel)
      0:       return m.rrdy;
      1:       return m.rdrdy;
      default: return m.wacpt;
    endcase
  endfunction

  task automatic wait_lvl(input int sel, input logic lvl, input string tag);
    int n = 0;
    while (out_sel(sel) !== lvl && n < 64) begin
      tick();
      n++;
    end
    check(tag, 32'(out_sel(sel)), 32'(lvl));
  endtask

  function automatic logic [15:0] expect_word(input logic [15:0] addr, input int b);
    return model[(int'(addr) & 'h3FC) + b];
  endfunction

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input string tag);
    m.bus_in = addr;
    m.wrqst  = 1'b1;
    wait_lvl(2, 1'b1, {tag, "_aack"});
    m.wrqst = 1'b0;
    wait_lvl(2, 1'b0, {tag, "_arel"});
    m.bus_in = data;
    m.wrqst  = 1'b1;
    wait_lvl(2, 1'b1, {tag, "_dack"});
    m.wrqst = 1'b0;
    wait_lvl(2, 1'b0, {tag, "_drel"});
    model[int'(addr) & 'h3FF] = data;
  endtask

  task automatic do_read(input logic [15:0] addr, input bit issue, input int stall_beat,
                         input int stall_cyc, input string tag);
    logic [15:0] exp;
    if (issue) begin
      m.bus_in = addr;
      m.rrqst  = 1'b1;
      wait_lvl(0, 1'b1, {tag, "_rrdy"});
      m.rrqst  = 1'b0;
      m.bus_in = 16'($urandom);
    end
    for (int b = 0; b < 4; b++) begin
      exp = expect_word(addr, b);
      wait_lvl(1, 1'b1, $sformatf("%s_b%0d_rdrdy", tag, b));
      check($sformatf("%s_b%0d_data", tag, b), 32'(m.bus_out), 32'(exp));
      check($sformatf("%s_b%0d_oe", tag, b), 32'(m.bus_oe), 32'd1);
      if (b == stall_beat) begin
        for (int k = 0; k < stall_cyc; k++) begin
          tick();
          check($sformatf("%s_stall%0d", tag, k), {14'd0, m.rdrdy, m.bus_oe, m.bus_out},
                {14'd0, 1'b1, 1'b1, exp});
        end
      end
      m.rdacpt = 1'b1;
      wait_lvl(1, 1'b0, $sformatf("%s_b%0d_rel", tag, b));
      m.rdacpt = 1'b0;
    end
    tick();
    check({tag, "_idle"}, 32'(u_dut.state), 32'(IDLE));
  endtask

  // Continuous protocol invariants on the main instance.
  logic        prev_rdrdy = 1'b0;
  logic [15:0] prev_bus   = '0;
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      check("onehot0_rrdy_rdrdy_wacpt", 32'($onehot0({m.rrdy, m.rdrdy, m.wacpt})), 32'd1);
      check("bus_oe_eq_rdrdy", 32'(m.bus_oe), 32'(m.rdrdy));
      if (prev_rdrdy && m.rdrdy) check("bus_out_hold", 32'(m.bus_out), 32'(prev_bus));
    end
    prev_rdrdy = m.rdrdy;
    prev_bus   = m.bus_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, gm, g5;
    logic [15:0] base, data, raddr;

    reset = 1'b1;
    m.bus_in = '0;  m.rrqst = 1'b0;  m.rdacpt = 1'b0;  m.wrqst = 1'b0;
    a0.bus_in = '0; a0.rrqst = 1'b0; a0.rdacpt = 1'b0; a0.wrqst = 1'b0;
    a5.bus_in = '0; a5.rrqst = 1'b0; a5.rdacpt = 1'b0; a5.wrqst = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {m.rrdy, m.rdrdy, m.wacpt, m.bus_oe, m.bus_out}, 32'd0);
    check("rst_state", 32'(u_dut.state), 32'(IDLE));
    reset = 1'b0;
    tick();

    // Preload and read block 0x40 through a misaligned address.
    for (int i = 0; i < 4; i++) do_write(16'h0040 + 16'(i), 16'h00A0 + 16'(i), $sformatf("pre40_%0d", i));
    do_read(16'h0041, 1'b1, -1, 0, "rd40");

    // Plain write-through, then a block read that includes it.
    do_write(16'h0100, 16'h1111, "pre100_0");
    do_write(16'h0101, 16'h2222, "pre100_1");
    do_write(16'h0103, 16'h4444, "pre100_3");
    do_write(16'h0102, 16'hBEEF, "wr102");
    do_read(16'h0100, 1'b1, -1, 0, "rd100");
    check("rd100_beat2_model", 32'(expect_word(16'h0100, 2)), 32'h0000BEEF);

    // Write-miss: write first, fill follows with no rrqst, carrying the new word.
    for (int i = 0; i < 4; i++) do_write(16'h0204 + 16'(i), 16'(16'h5000 + i), $sformatf("pre204_%0d", i));
    m.bus_in = 16'h0205;
    m.rrqst  = 1'b1;
    m.wrqst  = 1'b1;
    wait_lvl(2, 1'b1, "wm_aack");
    check("wm_no_rrdy", 32'(m.rrdy), 32'd0);
    m.rrqst = 1'b0;
    m.wrqst = 1'b0;
    wait_lvl(2, 1'b0, "wm_arel");
    m.bus_in = 16'h1234;
    m.wrqst  = 1'b1;
    wait_lvl(2, 1'b1, "wm_dack");
    m.wrqst = 1'b0;
    wait_lvl(2, 1'b0, "wm_drel");
    model['h205] = 16'h1234;
    do_read(16'h0205, 1'b0, -1, 0, "wmfill");

    // Stall rdacpt for 10 cycles in beat 2.
    do_read(16'h0040, 1'b1, 2, 10, "stall40");

    // Latency from the edge that samples rrqst low to rdrdy rising.
    m.bus_in = 16'h0040; a0.bus_in = 16'h0040; a5.bus_in = 16'h0040;
    m.rrqst = 1'b1; a0.rrqst = 1'b1; a5.rrqst = 1'b1;
    wait_lvl(0, 1'b1, "lat_rrdy");
    check("lat_rrdy_l0", 32'(a0.rrdy), 32'd1);
    check("lat_rrdy_l5", 32'(a5.rrdy), 32'd1);
    m.rrqst = 1'b0; a0.rrqst = 1'b0; a5.rrqst = 1'b0;
    g0 = -1; gm = -1; g5 = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (a0.rdrdy && g0 < 0) g0 = n - 1;
      if (m.rdrdy  && gm < 0) gm = n - 1;
      if (a5.rdrdy && g5 < 0) g5 = n - 1;
    end
    check("gap_rdlat0", 32'(g0), 32'd2);
    check("gap_rdlat2", 32'(gm), 32'd4);
    check("gap_rdlat5", 32'(g5), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Reset during beat 1 aborts; a fresh read starts again from beat 0.
    m.bus_in = 16'h0041;
    m.rrqst  = 1'b1;
    wait_lvl(0, 1'b1, "rst_rrdy");
    m.rrqst = 1'b0;
    wait_lvl(1, 1'b1, "rst_b0_rdrdy");
    check("rst_b0_data", 32'(m.bus_out), 32'h00A0);
    m.rdacpt = 1'b1;
    wait_lvl(1, 1'b0, "rst_b0_rel");
    m.rdacpt = 1'b0;
    wait_lvl(1, 1'b1, "rst_b1_rdrdy");
    check("rst_b1_data", 32'(m.bus_out), 32'h00A1);
    reset = 1'b1;
    tick();
    check("midrst_outputs", {m.rrdy, m.rdrdy, m.wacpt, m.bus_oe, m.bus_out}, 32'd0);
    check("midrst_state", 32'(u_dut.state), 32'(IDLE));
    reset = 1'b0;
    tick();
    do_read(16'h0041, 1'b1, -1, 0, "rd40_after_rst");

    // Top-of-RAM block reached through an out-of-range address.
    for (int i = 0; i < 4; i++) do_write(16'h03FC + 16'(i), 16'(16'hC000 + i * 16'h0101), $sformatf("pre3fc_%0d", i));
    do_read(16'hFFFF, 1'b1, -1, 0, "rdffff");

    // Random blocks with random offsets and ignored upper address bits.
    for (int t = 0; t < 6; t++) begin
      base = 16'($urandom_range(0, 255)) << 2;
      for (int i = 0; i < 4; i++) begin
        data = 16'($urandom);
        do_write(base + 16'(i) + (16'($urandom_range(0, 63)) << 10), data, $sformatf("rw%0d_%0d", t, i));
      end
      raddr = base | 16'($urandom_range(0, 3)) | (16'($urandom_range(0, 63)) << 10);
      do_read(raddr, 1'b1, t % 4, t, $sformatf("rr%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
